// File: rtl/log_lut_pkg.sv
// Shared defaults and types for the runtime-programmable log-offset lookup table.
package log_lut_pkg;

  localparam int unsigned LOG_IDX_W  = 4;
  localparam int unsigned LOG_DATA_W = 40;

  typedef logic [LOG_IDX_W-1:0]  log_idx_t;
  typedef logic [LOG_DATA_W-1:0] log_data_t;

endpackage

// File: rtl/log_lut_bank.sv
// Offset table storage: one guarded write port and NCH zero-forcing combinational read ports.
module log_lut_bank
  import log_lut_pkg::*;
#(
  parameter int unsigned IDX_W      = LOG_IDX_W,
  parameter int unsigned DATA_W     = LOG_DATA_W,
  parameter int unsigned NCH        = 2,
  parameter int unsigned ZERO_BELOW = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_we,
  input  logic [IDX_W-1:0]      i_addr,
  input  logic [DATA_W-1:0]     i_wdata,
  output logic                  o_err,
  input  logic [NCH*IDX_W-1:0]  i_rd_idx,
  output logic [NCH*DATA_W-1:0] o_rd_data
);

  localparam int unsigned Depth = 2 ** IDX_W;

  logic [DATA_W-1:0] r_mem [Depth];
  logic              r_err;
  logic              w_protected;

  assign w_protected = 32'(i_addr) < ZERO_BELOW;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < Depth; i++) r_mem[i] <= '0;
      r_err <= 1'b0;
    end else begin
      r_err <= i_we && w_protected;
      if (i_we && !w_protected) r_mem[i_addr] <= i_wdata;
    end
  end

  assign o_err = r_err;

  // Reads see the pre-edge contents, so a same-cycle write is not forwarded.
  for (genvar c = 0; c < NCH; c++) begin : g_rd
    logic [IDX_W-1:0] w_idx;
    assign w_idx = i_rd_idx[c*IDX_W +: IDX_W];
    assign o_rd_data[c*DATA_W +: DATA_W] = (32'(w_idx) < ZERO_BELOW) ? '0 : r_mem[w_idx];
  end

endmodule

// File: rtl/log_offset_lut_pipe.sv
// Multi-lane log-offset lookup with a single registered valid/ready output stage.
module log_offset_lut_pipe
  import log_lut_pkg::*;
#(
  parameter int unsigned IDX_W      = LOG_IDX_W,
  parameter int unsigned DATA_W     = LOG_DATA_W,
  parameter int unsigned NCH        = 2,
  parameter int unsigned ZERO_BELOW = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_cfg_we,
  input  logic [IDX_W-1:0]      i_cfg_addr,
  input  logic [DATA_W-1:0]     i_cfg_wdata,
  output logic                  o_cfg_err,
  input  logic                  i_in_valid,
  output logic                  o_in_ready,
  input  logic [NCH*IDX_W-1:0]  i_in_idx,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic [NCH*DATA_W-1:0] o_out_data
);

  logic [NCH*DATA_W-1:0] w_rd_data;
  logic                  w_accept;
  logic                  r_out_valid;
  logic [NCH*DATA_W-1:0] r_out_data;

  log_lut_bank #(
    .IDX_W      (IDX_W),
    .DATA_W     (DATA_W),
    .NCH        (NCH),
    .ZERO_BELOW (ZERO_BELOW)
  ) u_bank (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_we      (i_cfg_we),
    .i_addr    (i_cfg_addr),
    .i_wdata   (i_cfg_wdata),
    .o_err     (o_cfg_err),
    .i_rd_idx  (i_in_idx),
    .o_rd_data (w_rd_data)
  );

  assign o_in_ready = !r_out_valid || i_out_ready;
  assign w_accept   = i_in_valid && o_in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_rd_data;
    end else if (i_out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;

endmodule

// File: tb/tb_log_offset_lut_pipe.sv
// Directed self-checking bench for log_offset_lut_pipe with hand-computed expectations.
module tb_log_offset_lut_pipe;

  localparam int unsigned IDX_W  = 4;
  localparam int unsigned DATA_W = 40;
  localparam int unsigned NCH    = 2;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  cfg_we = 1'b0;
  logic [IDX_W-1:0]      cfg_addr = '0;
  logic [DATA_W-1:0]     cfg_wdata = '0;
  logic                  cfg_err;
  logic                  in_valid = 1'b0;
  logic                  in_ready;
  logic [NCH*IDX_W-1:0]  in_idx = '0;
  logic                  out_valid;
  logic                  out_ready = 1'b1;
  logic [NCH*DATA_W-1:0] out_data;

  int n_total = 0;
  int n_bad   = 0;

  logic [DATA_W-1:0] stream_exp [4];

  log_offset_lut_pipe u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_cfg_we    (cfg_we),
    .i_cfg_addr  (cfg_addr),
    .i_cfg_wdata (cfg_wdata),
    .o_cfg_err   (cfg_err),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_in_idx    (in_idx),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_out_data  (out_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [IDX_W-1:0] a, input logic [DATA_W-1:0] d);
    cfg_we    = 1'b1;
    cfg_addr  = a;
    cfg_wdata = d;
    tick();
    cfg_we    = 1'b0;
  endtask

  initial begin
    // Reset state
    #1;
    chk("rst_valid", 80'(out_valid), 80'd0);
    chk("rst_data", out_data, 80'd0);
    chk("rst_err", 80'(cfg_err), 80'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Park a nonzero beat in the output stage, then reset mid-stream
    cfg_write(4'd5, 40'hAB_CDEF_0123);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_idx    = {4'd5, 4'd5};
    tick();
    in_valid  = 1'b0;
    chk("pre_rst_valid", 80'(out_valid), 80'd1);
    chk("pre_rst_data", out_data, {40'hAB_CDEF_0123, 40'hAB_CDEF_0123});
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 80'(out_valid), 80'd0);
    chk("mid_rst_data", out_data, 80'd0);
    chk("mid_rst_err", 80'(cfg_err), 80'd0);
    tick();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("post_rst_no_out", 80'(out_valid), 80'd0);
    in_valid = 1'b1;
    in_idx   = {4'd5, 4'd5};
    tick();
    in_valid = 1'b0;
    chk("post_rst_valid", 80'(out_valid), 80'd1);
    chk("post_rst_cleared", out_data, 80'd0);
    tick();
    chk("drain_valid", 80'(out_valid), 80'd0);

    // Program and read
    cfg_write(4'd2, 40'h01A98A9800);
    cfg_write(4'd3, 40'h03F44F4400);
    in_valid = 1'b1;
    in_idx   = {4'd3, 4'd2};
    tick();
    in_valid = 1'b0;
    chk("prog_valid", 80'(out_valid), 80'd1);
    chk("prog_data", out_data, {40'h03F44F4400, 40'h01A98A9800});

    // Protected write
    cfg_we    = 1'b1;
    cfg_addr  = 4'd1;
    cfg_wdata = 40'hFFFF;
    #1;
    chk("err_before", 80'(cfg_err), 80'd0);
    tick();
    cfg_we = 1'b0;
    chk("err_pulse", 80'(cfg_err), 80'd1);
    in_valid = 1'b1;
    in_idx   = {4'd1, 4'd1};
    tick();
    in_valid = 1'b0;
    chk("err_one_cycle", 80'(cfg_err), 80'd0);
    chk("prot_read", out_data, 80'd0);
    chk("prot_read_valid", 80'(out_valid), 80'd1);

    // Backpressure
    in_valid = 1'b1;
    in_idx   = {4'd3, 4'd2};
    tick();
    out_ready = 1'b0;
    in_idx    = {4'd2, 4'd3};
    #1;
    chk("bp_ready0", 80'(in_ready), 80'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("bp_valid%0d", i), 80'(out_valid), 80'd1);
      chk($sformatf("bp_data%0d", i), out_data, {40'h03F44F4400, 40'h01A98A9800});
      chk($sformatf("bp_ready%0d", i), 80'(in_ready), 80'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 80'(in_ready), 80'd1);
    tick();
    in_valid = 1'b0;
    chk("bp_new_valid", 80'(out_valid), 80'd1);
    chk("bp_new_data", out_data, {40'h01A98A9800, 40'h03F44F4400});
    tick();

    // Same-cycle write and lookup returns the old entry
    cfg_write(4'd4, 40'h11);
    cfg_we    = 1'b1;
    cfg_addr  = 4'd4;
    cfg_wdata = 40'h22;
    in_valid  = 1'b1;
    in_idx    = {4'd4, 4'd4};
    tick();
    cfg_we = 1'b0;
    chk("coll_old", out_data, {40'h11, 40'h11});
    tick();
    in_valid = 1'b0;
    chk("coll_new", out_data, {40'h22, 40'h22});
    tick();

    // Back-to-back streaming; lane1 reads a protected index throughout
    cfg_write(4'd5, 40'h55_5555_5555);
    stream_exp[0] = 40'h01A98A9800;
    stream_exp[1] = 40'h03F44F4400;
    stream_exp[2] = 40'h22;
    stream_exp[3] = 40'h55_5555_5555;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_idx = {4'd0, 4'(2 + i)};
      #1;
      chk($sformatf("st_ready%0d", i), 80'(in_ready), 80'd1);
      tick();
      chk($sformatf("st_valid%0d", i), 80'(out_valid), 80'd1);
      chk($sformatf("st_data%0d", i), out_data, {40'd0, stream_exp[i]});
    end
    in_valid = 1'b0;
    tick();
    chk("st_end_valid", 80'(out_valid), 80'd0);
    chk("st_hold_data", out_data, {40'd0, 40'h55_5555_5555});

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
